inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder and instruction-memory writer: the packing counterpart of the FPU pipeline's Decode stage. It accepts field tuples (RL, RR, RD, OP) over a valid/ready handshake and packs each into a 17-bit instruction word. Packed words are buffered in a small FIFO and written to sequential instruction-memory addresses through a valid/ready write port. Bench and loader logic use it to fill instruction memory with programs that Decode will later unpack bit-exactly.

## Interface
Parameters:
- ISIZE, 17, instruction width; must equal `ISIZE.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- AW, 8, instruction-memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  encoder can accept a tuple.
- in_rl  in  5  left source register.
- in_rr  in  5  right source register.
- in_rd  in  5  destination register.
- in_op  in  2  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- start  in  1  one-cycle pulse that loads the write address.
- start_addr  in  AW  base address loaded by start.
- mem_valid  out  1  write request.
- mem_ready  in  1  memory accepts the write.
- mem_addr  out  AW  write address.
- mem_data  out  ISIZE  packed instruction.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- wrapped  out  1  sticky flag: the address wrapped past 2^AW-1.

## Operation
- Packing: word = {rl, rr, rd, op}.
  - rl occupies bits [16:12], rr [11:7], rd [6:2], op [1:0].
  - There is no field validation; every 5-bit and 2-bit value is legal.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH). in_ready depends only on registered state, never on mem_ready.
- Pop: occurs when mem_valid && mem_ready. mem_valid = (count != 0).
  - mem_data is the FIFO head.
  - mem_addr is the registered write pointer.
- FIFO: circular with read and write indices; indices wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Push while full cannot occur, because in_ready is low.
  - Pop while empty cannot occur, because mem_valid is low.
- Write pointer:
  - Each pop increments it by 1 modulo 2^AW.
  - A pop at address 2^AW-1 goes to 0 and sets wrapped.
  - start loads start_addr and clears wrapped. start has priority over a same-cycle pop increment; that pop still writes at the old address.
  - start does not flush the FIFO. Pending words are written starting at start_addr.
- Order: words are written in push order, one per accepted pop, with no drops or duplication.

## Timing
- Reset (asynchronous, takes effect immediately):
  - in_ready=1, mem_valid=0, count=0, mem_addr=0, mem_data=0, wrapped=0.
  - FIFO contents are don't-care but mem_data reads 0.
- Latency: a push into an empty FIFO at edge N gives mem_valid=1 with that word after edge N. Latency is 1 cycle and there is no combinational in→mem path.
- Throughput: 1 word/cycle sustained while mem_ready=1.
- mem_valid, mem_data and mem_addr hold stable while mem_valid && !mem_ready.
- count updates on the edge of the push or pop.
- Reset mid-operation: all pending words are discarded and the outputs above are restored. The first push after reset deasserts is accepted normally.
- start while mem_ready=0: the next pop writes at start_addr.

## Test plan
- Single encode:
  - Stimulus: rl=12, rr=11, rd=10, op=2, start_addr=0x10 via start, mem_ready=1.
  - Required: one cycle later mem_valid=1, mem_data=17'h0C5AA, mem_addr=0x10. The next cycle mem_valid=0 and mem_addr=0x11.
- Fill/backpressure:
  - Stimulus: mem_ready=0, push 5 tuples.
  - Required: the first 4 are accepted, count=4, in_ready=0 on the 5th.
  - Then raise mem_ready: words appear in order at consecutive addresses, and in_ready=1 after the first pop.
- Streaming:
  - Stimulus: push every cycle with mem_ready=1 for 16 words.
  - Required: count stays ≤1, 16 consecutive writes, all data matching.
- Wrap:
  - Stimulus: start_addr=0xFE, push 3 words.
  - Required: addresses 0xFE, 0xFF, 0x00; wrapped=1 after the third write; a subsequent start clears wrapped.
- start collision:
  - Stimulus: pop at address 0x05 in the same cycle as start with start_addr=0x40.
  - Required: that word is written at 0x05 and the next word at 0x40.
- Reset mid-operation:
  - Stimulus: 3 words buffered with mem_ready=0, then pulse rst_n low.
  - Required: count=0, mem_valid=0, mem_addr=0 immediately; no stale word is written afterward.
- Round-trip: all 4 op values with random registers, packed words fed to Decode, must return identical fields.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder
//   Packs (rl, rr, rd, op) field tuples into instruction words and writes
//   them to consecutive instruction-memory addresses through a small FIFO.
//   Word layout: {rl[16:12], rr[11:7], rd[6:2], op[1:0]}.
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   tuple handshake; in_rl/in_rr/in_rd/in_op fields
//   start/start_addr load the write pointer (clears wrapped)
//   mem_valid/ready  write handshake; mem_addr, mem_data = FIFO head
//   count            FIFO occupancy
//   wrapped          sticky: the write pointer rolled over past 2^AW-1
module inst_encoder #(
  parameter int ISIZE = 17,
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_rl,
  input  logic [4:0]                 in_rr,
  input  logic [4:0]                 in_rd,
  input  logic [1:0]                 in_op,
  input  logic                       start,
  input  logic [AW-1:0]              start_addr,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [AW-1:0]              mem_addr,
  output logic [ISIZE-1:0]           mem_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       wrapped
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0] rl;
    logic [4:0] rr;
    logic [4:0] rd;
    logic [1:0] op;
  } inst_t;

  inst_t                        inst;
  logic [DEPTH-1:0][ISIZE-1:0]  fifo;
  logic [IW-1:0]                rd_idx, wr_idx;
  logic [AW-1:0]                wptr;
  logic                         push, pop;

  assign inst = '{rl: in_rl, rr: in_rr, rd: in_rd, op: in_op};

  // Handshakes depend only on registered occupancy: no in->mem comb path.
  assign in_ready  = (count != FULL);
  assign mem_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = mem_valid && mem_ready;

  // Storage is not reset; gating the head keeps mem_data at 0 when empty.
  assign mem_data = mem_valid ? fifo[rd_idx] : '0;
  assign mem_addr = wptr;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_idx] <= ISIZE'(inst);
  end

  // Indices are IW bits wide, so DEPTH being a power of two makes them wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // start wins over a same-cycle pop increment; that pop already used the
  // old address, since mem_addr is the registered pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      wrapped <= 1'b0;
    end else if (start) begin
      wptr    <= start_addr;
      wrapped <= 1'b0;
    end else if (pop) begin
      wptr <= wptr + 1'b1;
      if (wptr == '1) wrapped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rl, in_rr, in_rd;
  logic [1:0]  in_op;
  logic        start;
  logic [7:0]  start_addr;
  logic        mem_valid, mem_ready;
  logic [7:0]  mem_addr;
  logic [16:0] mem_data;
  logic [2:0]  count;
  logic        wrapped;

  inst_encoder #(.ISIZE(17), .DEPTH(4), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rl(in_rl), .in_rr(in_rr), .in_rd(in_rd), .in_op(in_op),
    .start(start), .start_addr(start_addr),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .count(count), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word packing by field weights.
  function automatic int pack(input int rl, input int rr, input int rd, input int op);
    return rl * 4096 + rr * 128 + rd * 4 + op;
  endfunction

  // Model: a queue of pending words, an integer address and a sticky flag.
  int q[$];
  int m_addr = 0;
  bit m_wrapped = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_addr = 0;
      m_wrapped = 0;
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && (q.size() < 4);
      do_pop  = (q.size() != 0) && mem_ready;
      if (do_pop) begin
        void'(q.pop_front());
        if (m_addr == 255) m_wrapped = 1;
        m_addr = (m_addr + 1) % 256;
      end
      if (start) begin
        m_addr = start_addr;
        m_wrapped = 0;
      end
      if (do_push) q.push_back(pack(in_rl, in_rr, in_rd, in_op));
    end
  end

  // Compare process and write log, sampled mid-cycle.
  int pops = 0;
  int wlog[$];
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",  in_ready,  (q.size() < 4) ? 1 : 0);
      chk("mem_valid", mem_valid, (q.size() != 0) ? 1 : 0);
      chk("count",     count,     q.size());
      chk("mem_data",  mem_data,  (q.size() != 0) ? q[0] : 0);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("wrapped",   wrapped,   m_wrapped);
      if (mem_valid && mem_ready) begin
        pops++;
        wlog.push_back(int'(mem_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input int rl, input int rr, input int rd, input int op);
    in_valid = v;
    in_rl = 5'(rl); in_rr = 5'(rr); in_rd = 5'(rd); in_op = 2'(op);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int p0;
    rst_n = 1'b0;
    in_valid = 0; in_rl = 0; in_rr = 0; in_rd = 0; in_op = 0;
    start = 0; start_addr = 0; mem_ready = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_wrapped", wrapped, 0);
    #20;
    rst_n = 1'b1;
    tick();

    // Single encode
    set_in(1, 12, 11, 10, 2);
    start = 1; start_addr = 8'h10; mem_ready = 1;
    tick();
    set_in(0, 0, 0, 0, 0); start = 0;
    chk("single_valid", mem_valid, 1);
    chk("single_data", mem_data, 17'h0C5AA);
    chk("single_addr", mem_addr, 8'h10);
    tick();
    chk("single_valid_after", mem_valid, 0);
    chk("single_addr_after", mem_addr, 8'h11);

    // Fill / backpressure
    mem_ready = 0;
    p0 = pops;
    for (int i = 0; i < 5; i++) begin
      set_in(1, i + 1, i + 2, i + 3, i % 4);
      if (i == 4) begin
        chk("fill_in_ready_5th", in_ready, 0);
        chk("fill_count", count, 4);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0);
    mem_ready = 1;
    tick();
    chk("fill_ready_after_pop", in_ready, 1);
    chk("fill_count_after_pop", count, 3);
    idle(4);
    chk("fill_writes", pops - p0, 4);
    chk("fill_last_word", wlog[wlog.size()-1], pack(4, 5, 6, 3));

    // Streaming
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      set_in(1, (i * 7) % 32, (i * 3 + 1) % 32, 31 - i, i % 4);
      tick();
      chk("stream_count_le1", (count <= 1) ? 1 : 0, 1);
    end
    set_in(0, 0, 0, 0, 0);
    idle(2);
    chk("stream_writes", pops - p0, 16);

    // Wrap
    start = 1; start_addr = 8'hFE;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, i, i, i, i);
      tick();
    end
    set_in(0, 0, 0, 0, 0);
    idle(2);
    chk("wrap_flag", wrapped, 1);
    chk("wrap_addr", mem_addr, 8'h01);
    start = 1; start_addr = 8'h00;
    tick();
    start = 0;
    chk("wrap_cleared", wrapped, 0);

    // start collision
    mem_ready = 0;
    start = 1; start_addr = 8'h05;
    tick();
    start = 0;
    set_in(1, 1, 2, 3, 1); tick();
    set_in(1, 4, 5, 6, 2); tick();
    set_in(0, 0, 0, 0, 0);
    start = 1; start_addr = 8'h40; mem_ready = 1;
    chk("coll_addr_before", mem_addr, 8'h05);
    chk("coll_data_before", mem_data, pack(1, 2, 3, 1));
    tick();
    start = 0;
    chk("coll_addr_after", mem_addr, 8'h40);
    chk("coll_data_after", mem_data, pack(4, 5, 6, 2));
    idle(2);

    // Reset mid-operation
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 9, 9, 9, i); tick();
    end
    set_in(0, 0, 0, 0, 0);
    chk("mid_count_before", count, 3);
    rst_n = 0;
    #1;
    chk("mid_count", count, 0);
    chk("mid_valid", mem_valid, 0);
    chk("mid_addr", mem_addr, 0);
    idle(2);
    rst_n = 1;
    mem_ready = 1;
    p0 = pops;
    idle(3);
    chk("mid_no_stale", pops - p0, 0);
    set_in(1, 3, 3, 3, 3);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("mid_first_push", mem_data, pack(3, 3, 3, 3));
    idle(2);

    // Round trip through a Decode-style unpack
    begin
      int rl[4], rr[4], rd[4];
      int base;
      base = wlog.size();
      for (int i = 0; i < 4; i++) begin
        rl[i] = $urandom_range(31); rr[i] = $urandom_range(31); rd[i] = $urandom_range(31);
        set_in(1, rl[i], rr[i], rd[i], i);
        tick();
      end
      set_in(0, 0, 0, 0, 0);
      idle(3);
      chk("rt_writes", wlog.size() - base, 4);
      for (int i = 0; i < 4 && base + i < wlog.size(); i++) begin
        int w;
        w = wlog[base + i];
        chk("rt_rl", w / 4096, rl[i]);
        chk("rt_rr", (w / 128) % 32, rr[i]);
        chk("rt_rd", (w / 4) % 32, rd[i]);
        chk("rt_op", w % 4, i);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
